// File: rtl/fifo_test_sequencer.sv
// Loop sequencer for the asymmetric-width FIFO demo: FILL, DRAIN, STREAM on led_clk.
// Optional per-phase watchdog enabled by defining SEQ_WATCHDOG_EN.
module fifo_test_sequencer #(
  parameter int SYNC_STAGE     = 2,
  parameter int STREAM_CYCLES  = 1024,
  parameter int LOOP_W         = 8,
  parameter int BLINK_W        = 20,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              led_clk,
  input  logic              sys_rst,
  input  logic              run_en,
  input  logic              pll_lock,
  input  logic              rst_busy,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              rdata_error,
  output logic              wr_allow,
  output logic              rd_allow,
  output logic              led_blink,
  output logic              led_error,
  output logic [2:0]        state_o,
  output logic [LOOP_W-1:0] loop_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    FILL     = 3'd2,
    DRAIN    = 3'd3,
    STREAM   = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam int PH_LIM = (STREAM_CYCLES > TIMEOUT_CYCLES) ? STREAM_CYCLES : TIMEOUT_CYCLES;
  localparam int PH_W   = $clog2(PH_LIM + 1);

  logic [SYNC_STAGE-1:0] r_sync_pll, r_sync_busy, r_sync_full, r_sync_empty, r_sync_err;
  logic                  w_s_pll_lock, w_s_rst_busy, w_s_fifo_full, w_s_fifo_empty, w_s_rdata_error;

  state_t                r_state, w_next;
  logic [PH_W-1:0]       r_phase;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic [LOOP_W-1:0]     r_loop;
  logic                  r_wr_allow, r_rd_allow, r_led_blink, r_led_error;
  logic                  w_stream_done, w_timeout;

  // The empty chain resets to 1 so a freshly reset FIFO is not seen as holding data.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync_pll   <= '0;
      r_sync_busy  <= '0;
      r_sync_full  <= '0;
      r_sync_empty <= '1;
      r_sync_err   <= '0;
    end else begin
      r_sync_pll   <= {r_sync_pll[SYNC_STAGE-2:0],   pll_lock};
      r_sync_busy  <= {r_sync_busy[SYNC_STAGE-2:0],  rst_busy};
      r_sync_full  <= {r_sync_full[SYNC_STAGE-2:0],  fifo_full};
      r_sync_empty <= {r_sync_empty[SYNC_STAGE-2:0], fifo_empty};
      r_sync_err   <= {r_sync_err[SYNC_STAGE-2:0],   rdata_error};
    end
  end

  assign w_s_pll_lock    = r_sync_pll[SYNC_STAGE-1];
  assign w_s_rst_busy    = r_sync_busy[SYNC_STAGE-1];
  assign w_s_fifo_full   = r_sync_full[SYNC_STAGE-1];
  assign w_s_fifo_empty  = r_sync_empty[SYNC_STAGE-1];
  assign w_s_rdata_error = r_sync_err[SYNC_STAGE-1];

  assign w_stream_done = (r_phase == PH_W'(STREAM_CYCLES - 1));
`ifdef SEQ_WATCHDOG_EN
  assign w_timeout = (r_phase == PH_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Priority: compare error, then run_en drop, then reset-busy, then phase exits.
  always_comb begin
    w_next = r_state;
    if (w_s_rdata_error) begin
      w_next = FAULT;
    end else if (r_state != FAULT && !run_en) begin
      w_next = IDLE;
    end else if (w_s_rst_busy && (r_state == FILL || r_state == DRAIN || r_state == STREAM)) begin
      w_next = WAIT_RDY;
    end else begin
      case (r_state)
        IDLE:     w_next = WAIT_RDY;
        WAIT_RDY: if (w_s_pll_lock && !w_s_rst_busy) w_next = FILL;
                  else if (w_timeout)                w_next = FAULT;
        FILL:     if (w_s_fifo_full)                 w_next = DRAIN;
                  else if (w_timeout)                w_next = FAULT;
        DRAIN:    if (w_s_fifo_empty)                w_next = STREAM;
                  else if (w_timeout)                w_next = FAULT;
        STREAM:   if (w_stream_done)                 w_next = FILL;
        FAULT:    w_next = FAULT;
        default:  w_next = IDLE;
      endcase
    end
  end

  // Gates and LEDs are registered from the next state so they move with state_o.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_blink_cnt <= '0;
      r_loop      <= '0;
      r_wr_allow  <= 1'b0;
      r_rd_allow  <= 1'b0;
      r_led_blink <= 1'b0;
      r_led_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (w_next != r_state)  r_phase <= '0;
      else if (r_phase != '1) r_phase <= r_phase + 1'b1;
      if (r_state == STREAM && w_next == FILL) r_loop <= r_loop + 1'b1;
      r_wr_allow  <= (w_next == FILL) || (w_next == STREAM);
      r_rd_allow  <= (w_next == DRAIN) || (w_next == STREAM);
      r_led_error <= (w_next == FAULT);
      if (w_next == FAULT)     r_led_blink <= 1'b1;
      else if (&r_blink_cnt)   r_led_blink <= ~r_led_blink;
    end
  end

  assign wr_allow   = r_wr_allow;
  assign rd_allow   = r_rd_allow;
  assign led_blink  = r_led_blink;
  assign led_error  = r_led_error;
  assign state_o    = r_state;
  assign loop_count = r_loop;

endmodule

// File: tb/tb_fifo_test_sequencer.sv
// Directed bench for fifo_test_sequencer with short stream/blink/timeout parameters.
module tb_fifo_test_sequencer;

  logic       led_clk, sys_rst, run_en, pll_lock, rst_busy, fifo_full, fifo_empty, rdata_error;
  logic       wr_allow, rd_allow, led_blink, led_error;
  logic [2:0] state_o;
  logic [7:0] loop_count;

  int n_pass  = 0;
  int n_total = 0;
  int loop_bad = 0;
  logic b;

  fifo_test_sequencer #(
    .SYNC_STAGE(2), .STREAM_CYCLES(16), .LOOP_W(8), .BLINK_W(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .led_clk(led_clk), .sys_rst(sys_rst), .run_en(run_en), .pll_lock(pll_lock),
    .rst_busy(rst_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rdata_error(rdata_error), .wr_allow(wr_allow), .rd_allow(rd_allow),
    .led_blink(led_blink), .led_error(led_error), .state_o(state_o), .loop_count(loop_count)
  );

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge led_clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (state_o !== tgt && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {29'd0, state_o}, {29'd0, tgt});
  endtask

  // One full FILL->DRAIN->STREAM->FILL pass starting in FILL.
  task automatic do_loop();
    fifo_full = 1'b1;
    tick(3);
    if (state_o !== 3'd3) loop_bad++;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    tick(3);
    if (state_o !== 3'd4) loop_bad++;
    fifo_empty = 1'b0;
    tick(16);
    if (state_o !== 3'd2) loop_bad++;
  endtask

  initial begin
    sys_rst = 1'b1; run_en = 1'b0; pll_lock = 1'b0; rst_busy = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1; rdata_error = 1'b0;
    tick(3);
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_wr", {31'd0, wr_allow}, 32'd0);
    chk("rst_rd", {31'd0, rd_allow}, 32'd0);
    chk("rst_blink", {31'd0, led_blink}, 32'd0);
    chk("rst_err", {31'd0, led_error}, 32'd0);
    chk("rst_loop", {24'd0, loop_count}, 32'd0);
    sys_rst = 1'b0;
    tick(2);
    chk("idle_hold", {29'd0, state_o}, 32'd0);

    run_en = 1'b1; pll_lock = 1'b1;
    tick(1);
    chk("to_wait", {29'd0, state_o}, 32'd1);
    tick(1);
    chk("wait_sync", {29'd0, state_o}, 32'd1);
    chk("wait_wr", {31'd0, wr_allow}, 32'd0);
    tick(1);
    chk("to_fill", {29'd0, state_o}, 32'd2);
    chk("fill_wr", {31'd0, wr_allow}, 32'd1);
    chk("fill_rd", {31'd0, rd_allow}, 32'd0);

    b = led_blink;
    tick(4);
    chk("blink_toggle", {31'd0, led_blink}, {31'd0, !b});

    fifo_full = 1'b1; fifo_empty = 1'b0;
    tick(2);
    chk("full_sync", {29'd0, state_o}, 32'd2);
    tick(1);
    chk("to_drain", {29'd0, state_o}, 32'd3);
    chk("drain_wr", {31'd0, wr_allow}, 32'd0);
    chk("drain_rd", {31'd0, rd_allow}, 32'd1);

    fifo_full = 1'b0; fifo_empty = 1'b1;
    tick(3);
    chk("to_stream", {29'd0, state_o}, 32'd4);
    chk("stream_wr", {31'd0, wr_allow}, 32'd1);
    chk("stream_rd", {31'd0, rd_allow}, 32'd1);
    fifo_empty = 1'b0;
    tick(15);
    chk("stream_hold", {29'd0, state_o}, 32'd4);
    tick(1);
    chk("stream_done", {29'd0, state_o}, 32'd2);
    chk("loop_1", {24'd0, loop_count}, 32'd1);

    for (int i = 0; i < 254; i++) do_loop();
    chk("loop_255", {24'd0, loop_count}, 32'd255);
    do_loop();
    chk("loop_wrap", {24'd0, loop_count}, 32'd0);
    chk("wrap_state", {29'd0, state_o}, 32'd2);
    chk("loop_glitch", loop_bad, 32'd0);
    do_loop();

    fifo_full = 1'b1;
    tick(3);
    chk("drain2", {29'd0, state_o}, 32'd3);
    rst_busy = 1'b1; fifo_full = 1'b0;
    tick(3);
    chk("busy_wait", {29'd0, state_o}, 32'd1);
    chk("busy_wr", {31'd0, wr_allow}, 32'd0);
    chk("busy_rd", {31'd0, rd_allow}, 32'd0);
    rst_busy = 1'b0;
    tick(3);
    chk("resume_fill", {29'd0, state_o}, 32'd2);
    chk("resume_wr", {31'd0, wr_allow}, 32'd1);
    run_en = 1'b0;
    tick(1);
    chk("runen_idle", {29'd0, state_o}, 32'd0);
    chk("runen_wr", {31'd0, wr_allow}, 32'd0);
    chk("runen_loop", {24'd0, loop_count}, 32'd1);

    run_en = 1'b1;
    wait_state(3'd2, 10, "refill");
    fifo_full = 1'b1;
    tick(3);
    fifo_full = 1'b0; fifo_empty = 1'b1;
    tick(3);
    chk("stream2", {29'd0, state_o}, 32'd4);
    fifo_empty = 1'b0;
    rdata_error = 1'b1;
    tick(1);
    rdata_error = 1'b0;
    tick(2);
    chk("to_fault", {29'd0, state_o}, 32'd5);
    tick(2);
    chk("fault_wr", {31'd0, wr_allow}, 32'd0);
    chk("fault_rd", {31'd0, rd_allow}, 32'd0);
    chk("fault_led", {31'd0, led_error}, 32'd1);
    chk("fault_blink_a", {31'd0, led_blink}, 32'd1);
    tick(3);
    chk("fault_blink_b", {31'd0, led_blink}, 32'd1);
    run_en = 1'b0;
    tick(5);
    chk("fault_sticky", {29'd0, state_o}, 32'd5);
    sys_rst = 1'b1;
    #1;
    chk("arst_state", {29'd0, state_o}, 32'd0);
    chk("arst_err", {31'd0, led_error}, 32'd0);
    chk("arst_loop", {24'd0, loop_count}, 32'd0);
    tick(1);
    sys_rst = 1'b0;

    run_en = 1'b1;
    wait_state(3'd2, 10, "wd_fill");
`ifdef SEQ_WATCHDOG_EN
    tick(63);
    chk("wd_hold", {29'd0, state_o}, 32'd2);
    tick(1);
    chk("wd_fault", {29'd0, state_o}, 32'd5);
    chk("wd_led", {31'd0, led_error}, 32'd1);
    chk("wd_wr", {31'd0, wr_allow}, 32'd0);
`else
    tick(1000);
    chk("nowd_fill", {29'd0, state_o}, 32'd2);
    chk("nowd_wr", {31'd0, wr_allow}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
